// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, response error codes,
// FSM state values and the default data-memory depth.
package lsu_pkg;

    localparam int unsigned MEM_WORDS_DEF = 128;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE = 2'b10;
    localparam logic [1:0] ERR_SIZE  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RMW  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RMW  = ST_RMW,
        RESP = ST_RESP
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Little-endian lane handling: extracts a sign/zero-extended load value from a
// memory word and merges a store lane into an old word for read-modify-write.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] data,
    output logic [31:0] ext,
    output logic [31:0] merged
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        ext       = '0;
        merged    = word;
        byte_lane = word[{off, 3'b000} +: 8];
        half_lane = word[{off[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: begin
                ext = uns ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
                merged[{off, 3'b000} +: 8] = data[7:0];
            end
            SZ_HALF: begin
                ext = uns ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
                merged[{off[1], 4'b0000} +: 16] = data[15:0];
            end
            default: begin
                ext    = word;
                merged = data;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: turns byte-addressed load/store requests into word
// commands for the data memory, with RMW for sub-word stores and error reporting.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEF,
    parameter int unsigned MEM_AW    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [1:0]        resp_err,
    output logic [31:0]       resp_rdata,
    output logic              mem_read,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);

    localparam logic [29:0] WORD_LIM = 30'(MEM_WORDS);

    logic [1:0]        state;
    logic [MEM_AW-1:0] addr_q;
    logic [1:0]        off_q;
    logic [1:0]        size_q;
    logic [1:0]        err_q;
    logic              uns_q;
    logic              we_q;
    logic [31:0]       data_q;

    logic              accept;
    logic [1:0]        err_c;
    logic [MEM_AW-1:0] req_word;
    logic [31:0]       ext;
    logic [31:0]       merged;

    assign req_word  = req_addr[MEM_AW+1:2];
    assign req_ready = rst_n && (state == ST_IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        if (req_size == SZ_ILL)
            err_c = ERR_SIZE;
        else if ((req_size == SZ_HALF && req_addr[0]) ||
                 (req_size == SZ_WORD && req_addr[1:0] != 2'b00))
            err_c = ERR_ALIGN;
        else if (req_addr[31:2] >= WORD_LIM)
            err_c = ERR_RANGE;
        else
            err_c = ERR_OK;
    end

    // mem_rd is the read data for the command of the previous cycle: the old word
    // in RMW, the load word in RESP. Both use the same latched lane controls.
    lsu_align u_align (
        .word   (mem_rd),
        .off    (off_q),
        .size   (size_q),
        .uns    (uns_q),
        .data   (data_q),
        .ext    (ext),
        .merged (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            addr_q <= '0;
            off_q  <= '0;
            size_q <= '0;
            err_q  <= ERR_OK;
            uns_q  <= 1'b0;
            we_q   <= 1'b0;
            data_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        err_q  <= err_c;
                        we_q   <= req_we;
                        size_q <= req_size;
                        uns_q  <= req_unsigned;
                        off_q  <= req_addr[1:0];
                        data_q <= req_wdata;
                        if (err_c == ERR_OK)
                            addr_q <= req_word;
                        if (err_c == ERR_OK && req_we && req_size != SZ_WORD)
                            state <= ST_RMW;
                        else
                            state <= ST_RESP;
                    end
                end
                ST_RMW:  state <= ST_RESP;
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Only the SW accept cycle and the RMW cycle may drive a write.
    always_comb begin
        mem_read = 1'b1;
        mem_addr = addr_q;
        mem_wd   = '0;
        case (state)
            ST_IDLE: begin
                if (accept && err_c == ERR_OK) begin
                    mem_addr = req_word;
                    if (req_we && req_size == SZ_WORD) begin
                        mem_read = 1'b0;
                        mem_wd   = req_wdata;
                    end
                end
            end
            ST_RMW: begin
                mem_read = 1'b0;
                mem_wd   = merged;
            end
            default: ;
        endcase
    end

    assign resp_valid = (state == ST_RESP);
    assign resp_err   = resp_valid ? err_q : ERR_OK;
    assign resp_rdata = (resp_valid && !we_q && err_q == ERR_OK) ? ext : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed requests with literal expectations plus a
// per-cycle reference model of handshake, memory commands and responses.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [1:0]  resp_err;
    logic [31:0] resp_rdata;
    logic        mem_read;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    int n_chk = 0;
    int n_err = 0;

    load_store_unit #(.MEM_WORDS(128), .MEM_AW(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .mem_read     (mem_read),
        .mem_addr     (mem_addr),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Data memory environment: acts every cycle, read data one cycle later.
    logic [31:0] env_mem [0:255] = '{default: '0};
    always @(posedge clk) begin
        if (!mem_read)
            env_mem[mem_addr] <= mem_wd;
        mem_rd <= env_mem[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_chk++;
        n_err++;
        $display("FAIL %s: timed out at t=%0t", nm, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [1:0] m_err(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 2'd3;
        if ((sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)) return 2'd1;
        if (a / 4 >= 128) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [1:0] sz, input logic u);
        int sh = int'(a % 4) * 8;
        logic [31:0] v;
        if (sz == 2'd2) return w;
        v = w >> sh;
        if (sz == 2'd0) begin
            v = v & 32'hFF;
            if (!u && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else begin
            v = v & 32'hFFFF;
            if (!u && v >= 32'h8000) v = v | 32'hFFFF0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] w, input logic [31:0] d,
                                            input logic [31:0] a, input logic [1:0] sz);
        int sh = int'(a % 4) * 8;
        logic [31:0] mask;
        mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
        return (w & ~mask) | ((d << sh) & mask);
    endfunction

    logic [31:0] ref_mem [0:255] = '{default: '0};
    int          cyc = 0;
    int          busy_until = 0;
    int          resp_due = -1;
    int          wr_due = -1;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  exp_e;
    logic [31:0] exp_rd;
    int          resp_seen = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
                chk("rst_mem_read", {31'b0, mem_read}, 32'd1);
                chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
                busy_until = cyc;
                resp_due   = -1;
                wr_due     = -1;
            end else begin
                logic       exp_write;
                logic       exp_ready;
                logic [1:0] e;
                logic [7:0] wi;
                int         lat;
                exp_write = 1'b0;
                if (resp_due == cyc) begin
                    chk("m_resp_valid", {31'b0, resp_valid}, 32'd1);
                    chk("m_resp_err", {30'b0, resp_err}, {30'b0, exp_e});
                    chk("m_resp_rdata", resp_rdata, exp_rd);
                    resp_due = -1;
                end else begin
                    chk("m_resp_idle", {31'b0, resp_valid}, 32'd0);
                end
                if (resp_valid) resp_seen++;
                if (wr_due == cyc) begin
                    exp_write = 1'b1;
                    chk("m_rmw_addr", {24'b0, mem_addr}, {24'b0, wr_addr});
                    chk("m_rmw_wd", mem_wd, wr_data);
                    ref_mem[wr_addr] = wr_data;
                    wr_due = -1;
                end
                exp_ready = (cyc >= busy_until);
                chk("m_req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
                if (req_valid && exp_ready) begin
                    e      = m_err(req_size, req_addr);
                    wi     = req_addr[9:2];
                    lat    = 1;
                    exp_e  = e;
                    exp_rd = '0;
                    if (e == 2'd0) begin
                        chk("m_acc_addr", {24'b0, mem_addr}, {24'b0, wi});
                        if (!req_we) begin
                            exp_rd = m_load(ref_mem[wi], req_addr, req_size, req_unsigned);
                        end else if (req_size == 2'd2) begin
                            exp_write = 1'b1;
                            chk("m_sw_wd", mem_wd, req_wdata);
                            ref_mem[wi] = req_wdata;
                        end else begin
                            wr_due  = cyc + 1;
                            wr_addr = wi;
                            wr_data = m_merge(ref_mem[wi], req_wdata, req_addr, req_size);
                            lat     = 2;
                        end
                    end
                    resp_due   = cyc + lat;
                    busy_until = cyc + lat + 1;
                end
                chk("m_mem_read", {31'b0, mem_read}, {31'b0, ~exp_write});
            end
            cyc++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic set_req(input logic we, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] wd);
        req_we       = we;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = wd;
        req_valid    = 1'b1;
    endtask

    task automatic do_req(input string nm, input logic we, input logic [1:0] sz,
                          input logic u, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] e_err, input logic [31:0] e_rd, input int e_lat);
        int n;
        int lat;
        @(posedge clk); #1;
        set_req(we, sz, u, a, wd);
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            timeout_fail({nm, "_accept"});
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 6) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!resp_valid) begin
            timeout_fail({nm, "_resp"});
            return;
        end
        chk({nm, "_lat"}, lat, e_lat);
        chk({nm, "_err"}, {30'b0, resp_err}, {30'b0, e_err});
        chk({nm, "_rdata"}, resp_rdata, e_rd);
    endtask

    task automatic hold_req(input logic we, input logic [1:0] sz, input logic u,
                            input logic [31:0] a, input logic [31:0] wd);
        int n;
        set_req(we, sz, u, a, wd);
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) timeout_fail("stream_accept");
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_size = 2'b00;
        req_unsigned = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        #2;
        chk("reset_mem_read", {31'b0, mem_read}, 32'd1);
        chk("reset_mem_addr", {24'b0, mem_addr}, 32'd0);
        chk("reset_mem_wd", mem_wd, 32'd0);
        chk("reset_resp_err", {30'b0, resp_err}, 32'd0);
        chk("reset_resp_rdata", resp_rdata, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // store word then read back and sub-word loads
        do_req("sw_10",  1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 2'd0, 32'h0, 1);
        do_req("lw_10",  0, 2'd2, 0, 32'h10, 32'h0, 2'd0, 32'hDEADBEEF, 1);
        do_req("lb_13",  0, 2'd0, 0, 32'h13, 32'h0, 2'd0, 32'hFFFFFFDE, 1);
        do_req("lbu_13", 0, 2'd0, 1, 32'h13, 32'h0, 2'd0, 32'h000000DE, 1);
        do_req("lh_12",  0, 2'd1, 0, 32'h12, 32'h0, 2'd0, 32'hFFFFDEAD, 1);
        do_req("lhu_10", 0, 2'd1, 1, 32'h10, 32'h0, 2'd0, 32'h0000BEEF, 1);

        // read-modify-write stores
        do_req("sb_11",  1, 2'd0, 0, 32'h11, 32'h00000055, 2'd0, 32'h0, 2);
        do_req("lw_sb",  0, 2'd2, 0, 32'h10, 32'h0, 2'd0, 32'hDEAD55EF, 1);
        do_req("sh_12",  1, 2'd1, 0, 32'h12, 32'h00001234, 2'd0, 32'h0, 2);
        do_req("lw_sh",  0, 2'd2, 0, 32'h10, 32'h0, 2'd0, 32'h123455EF, 1);

        // errors and range boundary
        do_req("lw_mis",   0, 2'd2, 0, 32'h12, 32'h0, 2'd1, 32'h0, 1);
        do_req("lw_range", 0, 2'd2, 0, 32'h200, 32'h0, 2'd2, 32'h0, 1);
        do_req("sz_ill",   0, 2'd3, 0, 32'h10, 32'h0, 2'd3, 32'h0, 1);
        do_req("sz_ill_m", 1, 2'd3, 0, 32'h13, 32'h0, 2'd3, 32'h0, 1);
        do_req("sh_mis",   1, 2'd1, 0, 32'h11, 32'hFFFF, 2'd1, 32'h0, 1);
        do_req("sw_high",  1, 2'd2, 0, 32'h80000000, 32'h1, 2'd2, 32'h0, 1);
        do_req("lw_last",  0, 2'd2, 0, 32'h1FC, 32'h0, 2'd0, 32'h0, 1);
        do_req("lw_mem_intact", 0, 2'd2, 0, 32'h10, 32'h0, 2'd0, 32'h123455EF, 1);

        // reset during RMW abandons the write
        @(posedge clk); #1;
        set_req(1, 2'd0, 0, 32'h10, 32'h00000099);
        begin
            int n = 0;
            while (!req_ready && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rmw_write_cycle", {31'b0, mem_read}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rmw_rst_mem_read", {31'b0, mem_read}, 32'd1);
        chk("rmw_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rmw_rst_ready", {31'b0, req_ready}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        do_req("lw_after_rst", 0, 2'd2, 0, 32'h10, 32'h0, 2'd0, 32'h123455EF, 1);

        // idle stretch, then back-to-back requests held on req_valid
        repeat (50) @(posedge clk);
        #1;
        s0 = resp_seen;
        hold_req(1, 2'd2, 0, 32'h20, 32'h11223344);
        hold_req(0, 2'd0, 0, 32'h21, 32'h0);
        hold_req(1, 2'd1, 0, 32'h22, 32'h0000BEEF);
        hold_req(0, 2'd1, 1, 32'h22, 32'h0);
        hold_req(0, 2'd2, 0, 32'h21, 32'h0);
        hold_req(1, 2'd0, 0, 32'h23, 32'h000000A5);
        hold_req(0, 2'd0, 0, 32'h22, 32'h0);
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("stream_resp_count", resp_seen - s0, 32'd7);
        do_req("lw_stream", 0, 2'd2, 0, 32'h20, 32'h0, 2'd0, 32'hA5EF3344, 1);

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
